// File: rtl/msrv32_lsu_pkg.sv
// Shared msrv32 definitions for the load/store unit: FSM states, access sizes, byte masks.
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } lsu_state_t;

  // Size encodings; 2'b11 is treated as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/msrv32_lsu_if.sv
// Data-bus request/acknowledge interface between the LSU (master) and memory (slave).
interface msrv32_lsu_if;
  logic [31:0] dbus_addr_out;
  logic [31:0] dbus_wdata_out;
  logic [3:0]  dbus_wr_mask_out;
  logic        dbus_rd_req_out;
  logic        dbus_wr_req_out;
  logic        dbus_ack_in;
  logic [31:0] dbus_rdata_in;

  modport master (
    output dbus_addr_out, dbus_wdata_out, dbus_wr_mask_out,
           dbus_rd_req_out, dbus_wr_req_out,
    input  dbus_ack_in, dbus_rdata_in
  );

  modport slave (
    input  dbus_addr_out, dbus_wdata_out, dbus_wr_mask_out,
           dbus_rd_req_out, dbus_wr_req_out,
    output dbus_ack_in, dbus_rdata_in
  );
endinterface

// File: rtl/msrv32_lsu_align.sv
// Combinational lane logic: store replication/byte enables, alignment check, load extract/extend.
module msrv32_lsu_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [1:0]  req_size,
  input  logic [31:0] st_wdata_raw,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic        misaligned,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{ld_off, 3'b000} +: 8];
  assign half_v = rdata[{ld_off[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    st_wdata   = st_wdata_raw;
    st_mask    = MASK_WORD;
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        st_wdata = {4{st_wdata_raw[7:0]}};
        st_mask  = MASK_BYTE << req_off;
      end
      SZ_HALF: begin
        st_wdata   = {2{st_wdata_raw[15:0]}};
        st_mask    = MASK_HALF << req_off;
        misaligned = req_off[0];
      end
      default: misaligned = |req_off;
    endcase
  end

  always_comb begin
    ld_data = rdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data = {{16{~ld_unsigned & half_v[15]}}, half_v};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_lsu.sv
// msrv32 load/store unit: one bus transaction per memory instruction, pipeline stall while busy.
// Optional bus timeout enabled by defining MSRV32_LSU_TIMEOUT_EN.
module msrv32_lsu
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         ld_req_in,
  input  logic         st_req_in,
  input  logic         kill_in,
  input  logic [31:0]  addr_in,
  input  logic [31:0]  wdata_in,
  input  logic [1:0]   size_in,
  input  logic         unsigned_in,
  msrv32_lsu_if.master dbus,
  output logic         stall_out,
  output logic         load_valid_out,
  output logic [31:0]  load_data_out,
  output logic         misaligned_out,
  output logic         timeout_out
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("msrv32_lsu: TIMEOUT_CYC must be in 1..255");
  end

  lsu_state_t  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        rd_req_q;
  logic        wr_req_q;
  logic [1:0]  ld_off_q;
  logic [1:0]  ld_size_q;
  logic        ld_uns_q;

  logic        accept;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;
  logic        misaligned;
  logic [31:0] ld_data;

  assign accept    = (ld_req_in | st_req_in) & ~kill_in;
  assign stall_out = (state_q == ST_IDLE && accept) || (state_q == ST_BUSY);

  assign dbus.dbus_addr_out    = addr_q;
  assign dbus.dbus_wdata_out   = wdata_q;
  assign dbus.dbus_wr_mask_out = mask_q;
  assign dbus.dbus_rd_req_out  = rd_req_q;
  assign dbus.dbus_wr_req_out  = wr_req_q;

  msrv32_lsu_align u_align (
    .req_off      (addr_in[1:0]),
    .req_size     (size_in),
    .st_wdata_raw (wdata_in),
    .st_wdata     (st_wdata),
    .st_mask      (st_mask),
    .misaligned   (misaligned),
    .ld_off       (ld_off_q),
    .ld_size      (ld_size_q),
    .ld_unsigned  (ld_uns_q),
    .rdata        (dbus.dbus_rdata_in),
    .ld_data      (ld_data)
  );

`ifdef MSRV32_LSU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt_q;
  logic       timeout_q;
  assign timeout_out = timeout_q;
`else
  assign timeout_out = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the datapath registers are reset too, so the bus and load outputs read 0 after reset.
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      mask_q         <= '0;
      rd_req_q       <= 1'b0;
      wr_req_q       <= 1'b0;
      ld_off_q       <= '0;
      ld_size_q      <= '0;
      ld_uns_q       <= 1'b0;
      load_valid_out <= 1'b0;
      load_data_out  <= '0;
      misaligned_out <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
      to_cnt_q       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              state_q        <= ST_FAULT;
              misaligned_out <= 1'b1;
            end else begin
              state_q   <= ST_BUSY;
              addr_q    <= {addr_in[31:2], 2'b00};
              wdata_q   <= st_wdata;
              mask_q    <= st_mask;
              ld_off_q  <= addr_in[1:0];
              ld_size_q <= size_in;
              ld_uns_q  <= unsigned_in;
              // Load wins when both request lines are high.
              rd_req_q  <= ld_req_in;
              wr_req_q  <= ~ld_req_in;
`ifdef MSRV32_LSU_TIMEOUT_EN
              to_cnt_q  <= '0;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (dbus.dbus_ack_in) begin
            state_q  <= ST_DONE;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            if (rd_req_q) begin
              load_data_out  <= ld_data;
              load_valid_out <= 1'b1;
            end
          end
`ifdef MSRV32_LSU_TIMEOUT_EN
          else if (to_cnt_q == TIMEOUT_LAST) begin
            state_q   <= ST_FAULT;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
`endif
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_FAULT: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_lsu.sv
// Self-checking bench for msrv32_lsu: directed vector table, corner sequences, random vs. model.
module tb_msrv32_lsu;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ld_req_in, st_req_in, kill_in, unsigned_in;
  logic [31:0] addr_in, wdata_in;
  logic [1:0]  size_in;
  logic        stall_out, load_valid_out, misaligned_out, timeout_out;
  logic [31:0] load_data_out;

  msrv32_lsu_if bus ();

  msrv32_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .ld_req_in      (ld_req_in),
    .st_req_in      (st_req_in),
    .kill_in        (kill_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .size_in        (size_in),
    .unsigned_in    (unsigned_in),
    .dbus           (bus.master),
    .stall_out      (stall_out),
    .load_valid_out (load_valid_out),
    .load_data_out  (load_data_out),
    .misaligned_out (misaligned_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_load = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drop_inputs();
    ld_req_in   = 1'b0;
    st_req_in   = 1'b0;
    kill_in     = 1'b0;
    addr_in     = '0;
    wdata_in    = '0;
    size_in     = '0;
    unsigned_in = 1'b0;
  endtask

  // Reference model built from the access-size rules with plain arithmetic.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [31:0] addr, input logic [1:0] size);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] m = '0;
    int off = addr % 4;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes(size)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] w;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns, input logic [31:0] rdata);
    int    n = nbytes(size);
    longint v;
    longint span = longint'(1) << (8 * n);
    v = (longint'(rdata) >> (8 * (addr % 4))) % span;
    if (!uns && n < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Runs one instruction starting just after a rising edge with the unit in IDLE.
  task automatic run_txn(input string nm, input logic ld, input logic st,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                         input int k, input logic exp_mis, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    ld_req_in   = ld;
    st_req_in   = st;
    kill_in     = 1'b0;
    addr_in     = addr;
    wdata_in    = wdata;
    size_in     = size;
    unsigned_in = uns;
    bus.dbus_rdata_in = ~rdata;
    @(negedge clk_in);
    check({nm, "_stall_T"}, stall_out, 1'b1);
    @(posedge clk_in); #1;
    if (exp_mis) begin
      @(negedge clk_in);
      check({nm, "_misaligned"}, misaligned_out, 1'b1);
      check({nm, "_noreq"}, {bus.dbus_rd_req_out, bus.dbus_wr_req_out}, 2'b00);
      check({nm, "_stall_fault"}, stall_out, 1'b0);
      check({nm, "_novalid_fault"}, load_valid_out, 1'b0);
      @(posedge clk_in); #1;
      drop_inputs();
      @(negedge clk_in);
      check({nm, "_mis_pulse_end"}, misaligned_out, 1'b0);
    end else begin
      for (int c = 1; c <= k; c++) begin
        if (c == k) begin
          bus.dbus_ack_in   = 1'b1;
          bus.dbus_rdata_in = rdata;
        end
        @(negedge clk_in);
        check({nm, "_req"}, {bus.dbus_rd_req_out, bus.dbus_wr_req_out}, {ld, ~ld});
        check({nm, "_stall_busy"}, stall_out, 1'b1);
        check({nm, "_addr"}, bus.dbus_addr_out, {addr[31:2], 2'b00});
        if (!ld) begin
          check({nm, "_mask"}, bus.dbus_wr_mask_out, exp_mask);
          check({nm, "_wdata"}, bus.dbus_wdata_out, exp_wdata);
        end
        @(posedge clk_in); #1;
        bus.dbus_ack_in   = 1'b0;
        bus.dbus_rdata_in = ~rdata;
      end
      @(negedge clk_in);
      check({nm, "_valid_done"}, load_valid_out, ld);
      check({nm, "_data"}, load_data_out, ld ? exp_data : last_load);
      check({nm, "_req_done"}, {bus.dbus_rd_req_out, bus.dbus_wr_req_out}, 2'b00);
      check({nm, "_stall_done"}, stall_out, 1'b0);
      @(posedge clk_in); #1;
      drop_inputs();
      @(negedge clk_in);
      check({nm, "_valid_pulse_end"}, load_valid_out, 1'b0);
      if (ld) last_load = exp_data;
    end
    @(posedge clk_in); #1;
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          k;
    logic        mis;
    logic [3:0]  mask;
    logic [31:0] wd;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 0, 32'h0000_1000, 32'h0,         2'd2, 0, 32'hDEAD_BEEF, 1, 0, 4'h0, 32'h0,         32'hDEAD_BEEF};
    vecs[1]  = '{1, 0, 32'h0000_1003, 32'h0,         2'd0, 0, 32'h80FF_0000, 1, 0, 4'h0, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1, 0, 32'h0000_1003, 32'h0,         2'd0, 1, 32'h80FF_0000, 2, 0, 4'h0, 32'h0,         32'h0000_0080};
    vecs[3]  = '{0, 1, 32'h0000_2002, 32'h1234_ABCD, 2'd1, 0, 32'h0,         4, 0, 4'hC, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{1, 0, 32'h0000_3001, 32'h0,         2'd2, 0, 32'h0,         1, 1, 4'h0, 32'h0,         32'h0};
    vecs[5]  = '{0, 1, 32'h0000_0101, 32'h0000_00A5, 2'd0, 0, 32'h0,         2, 0, 4'h2, 32'hA5A5_A5A5, 32'h0};
    vecs[6]  = '{1, 0, 32'h0000_0002, 32'h0,         2'd1, 0, 32'h8001_7FFF, 3, 0, 4'h0, 32'h0,         32'hFFFF_8001};
    vecs[7]  = '{1, 0, 32'h0000_0000, 32'h0,         2'd1, 1, 32'h1234_F00D, 1, 0, 4'h0, 32'h0,         32'h0000_F00D};
    vecs[8]  = '{0, 1, 32'h0000_0003, 32'hFFFF_FFFF, 2'd1, 0, 32'h0,         1, 1, 4'h0, 32'h0,         32'h0};
    vecs[9]  = '{1, 1, 32'h0000_0010, 32'h5555_5555, 2'd2, 0, 32'hCAFE_F00D, 1, 0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vecs[10] = '{0, 1, 32'h0000_0020, 32'h89AB_CDEF, 2'd3, 0, 32'h0,         3, 0, 4'hF, 32'h89AB_CDEF, 32'h0};
    vecs[11] = '{1, 0, 32'h0000_0044, 32'h0,         2'd0, 0, 32'h0000_007F, 2, 0, 4'h0, 32'h0,         32'h0000_007F};

    rst_in = 1'b1;
    drop_inputs();
    bus.dbus_ack_in   = 1'b0;
    bus.dbus_rdata_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_stall", stall_out, 1'b0);
    check("rst_req", {bus.dbus_rd_req_out, bus.dbus_wr_req_out}, 2'b00);
    check("rst_addr", bus.dbus_addr_out, 32'h0);
    check("rst_mask", bus.dbus_wr_mask_out, 4'h0);
    check("rst_valid", load_valid_out, 1'b0);
    check("rst_data", load_data_out, 32'h0);
    check("rst_exc", {misaligned_out, timeout_out}, 2'b00);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata,
              vecs[i].size, vecs[i].uns, vecs[i].rdata, vecs[i].k, vecs[i].mis,
              vecs[i].mask, vecs[i].wd, vecs[i].data);

    // Killed request: no stall, no bus request; a stray ack in IDLE is ignored.
    ld_req_in = 1'b1;
    kill_in   = 1'b1;
    addr_in   = 32'h0000_0200;
    size_in   = 2'd2;
    bus.dbus_ack_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check("kill_stall", stall_out, 1'b0);
      check("kill_req", {bus.dbus_rd_req_out, bus.dbus_wr_req_out}, 2'b00);
      check("kill_valid", load_valid_out, 1'b0);
      @(posedge clk_in); #1;
    end
    bus.dbus_ack_in = 1'b0;
    drop_inputs();
    @(posedge clk_in); #1;

    // Reset while BUSY drops the request with no completion pulse.
    ld_req_in = 1'b1;
    addr_in   = 32'h0000_0040;
    size_in   = 2'd2;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("rstbusy_req", bus.dbus_rd_req_out, 1'b1);
    rst_in = 1'b1;
    drop_inputs();
    @(posedge clk_in); #1;
    check("rstbusy_req_drop", {bus.dbus_rd_req_out, bus.dbus_wr_req_out}, 2'b00);
    check("rstbusy_stall", stall_out, 1'b0);
    check("rstbusy_addr", bus.dbus_addr_out, 32'h0);
    check("rstbusy_data", load_data_out, 32'h0);
    rst_in = 1'b0;
    bus.dbus_ack_in = 1'b1;
    @(posedge clk_in); #1;
    bus.dbus_ack_in = 1'b0;
    check("rstbusy_novalid", load_valid_out, 1'b0);
    check("rstbusy_idle_stall", stall_out, 1'b0);
    last_load = '0;
    @(posedge clk_in); #1;

`ifdef MSRV32_LSU_TIMEOUT_EN
    // No ack for four BUSY cycles: request dropped, timeout pulses, later ack ignored.
    ld_req_in = 1'b1;
    addr_in   = 32'h0000_0080;
    size_in   = 2'd2;
    @(posedge clk_in); #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_in);
      check("to_req_busy", bus.dbus_rd_req_out, 1'b1);
      @(posedge clk_in); #1;
    end
    @(negedge clk_in);
    check("to_pulse", timeout_out, 1'b1);
    check("to_no_mis", misaligned_out, 1'b0);
    check("to_req_drop", bus.dbus_rd_req_out, 1'b0);
    check("to_stall", stall_out, 1'b0);
    @(posedge clk_in); #1;
    drop_inputs();
    bus.dbus_ack_in = 1'b1;
    @(negedge clk_in);
    check("to_pulse_end", timeout_out, 1'b0);
    @(posedge clk_in); #1;
    bus.dbus_ack_in = 1'b0;
    @(negedge clk_in);
    check("to_late_ack_valid", load_valid_out, 1'b0);
    check("to_late_ack_data", load_data_out, last_load);
    @(posedge clk_in); #1;
`else
    // Without the timeout feature a long ack delay simply completes.
    run_txn("longwait", 1'b1, 1'b0, 32'h0000_0084, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 20,
            1'b0, 4'h0, 32'h0, 32'h0BAD_F00D);
    check("no_timeout", timeout_out, 1'b0);
`endif

    // Random instructions against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic        ld, st, uns;
      logic [31:0] addr, wdata, rdata;
      logic [1:0]  size;
      int          k;
      ld    = 1'($urandom_range(0, 1));
      st    = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      k     = $urandom_range(1, 4);
      run_txn($sformatf("rnd%0d", i), ld, st, addr, wdata, size, uns, rdata, k,
              model_mis(addr, size), model_mask(addr, size), model_wdata(wdata, size),
              model_load(addr, size, uns, rdata));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
